// File: rtl/multicycle_controller_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Package : riscv_ctrl_pkg                                         |
// | Opcodes, datapath select encodings and FSM states for the        |
// | multicycle RISC-V controller.                                    |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
package riscv_ctrl_pkg;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RD1   = 2'b10;

    localparam logic [1:0] SRCB_RD2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    localparam logic [3:0] FETCH    = 4'd0;
    localparam logic [3:0] DECODE   = 4'd1;
    localparam logic [3:0] MEMADR   = 4'd2;
    localparam logic [3:0] MEMREAD  = 4'd3;
    localparam logic [3:0] MEMWB    = 4'd4;
    localparam logic [3:0] MEMWRITE = 4'd5;
    localparam logic [3:0] EXECR    = 4'd6;
    localparam logic [3:0] EXECI    = 4'd7;
    localparam logic [3:0] ALUWB    = 4'd8;
    localparam logic [3:0] BEQ      = 4'd9;
    localparam logic [3:0] JAL      = 4'd10;

    function automatic logic [1:0] imm_src_of(input logic [6:0] op);
        case (op)
            OP_SW:   return IMM_S;
            OP_BEQ:  return IMM_B;
            OP_JAL:  return IMM_J;
            default: return IMM_I;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/multicycle_controller_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Interface : multicycle_controller_if                             |
// | Instruction fields, flags and control lines between controller   |
// | (master) and datapath/memory (slave).                            |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
interface multicycle_controller_if;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       Zero;
    logic       MemReady;
    logic       PCWrite;
    logic       AdrSrc;
    logic       MemWrite;
    logic       IRWrite;
    logic [1:0] ResultSrc;
    logic [1:0] ALUSrcA;
    logic [1:0] ALUSrcB;
    logic       RegWrite;
    logic [1:0] ImmSrc;
    logic [2:0] ALUControl;
    logic       IllegalInstr;

    modport master (
        input  op, funct3, funct7b5, Zero, MemReady,
        output PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA,
               ALUSrcB, RegWrite, ImmSrc, ALUControl, IllegalInstr
    );

    modport slave (
        output op, funct3, funct7b5, Zero, MemReady,
        input  PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA,
               ALUSrcB, RegWrite, ImmSrc, ALUControl, IllegalInstr
    );
endinterface
`default_nettype wire

// File: rtl/multicycle_controller_alu_decoder.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module  : alu_decoder                                            |
// | Maps ALUOp, funct3, op[5] and funct7b5 to ALUControl.            |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module alu_decoder
    import riscv_ctrl_pkg::*;
(
    input  wire logic [1:0] alu_op,
    input  wire logic [2:0] funct3,
    input  wire logic       op5,
    input  wire logic       funct7b5,
    output logic      [2:0] alu_control
);
    always_comb begin
        alu_control = ALU_ADD;
        case (alu_op)
            ALUOP_SUB: alu_control = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct3)
                    // Only R-type encodes sub; I-type funct7 bits are immediate bits.
                    3'b000:  alu_control = (op5 & funct7b5) ? ALU_SUB : ALU_ADD;
                    3'b010:  alu_control = ALU_SLT;
                    3'b110:  alu_control = ALU_OR;
                    3'b111:  alu_control = ALU_AND;
                    default: alu_control = ALU_ADD;
                endcase
            end
            default: alu_control = ALU_ADD;
        endcase
    end
endmodule
`default_nettype wire

// File: rtl/multicycle_controller.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module  : multicycle_controller                                  |
// | Sequencing FSM for a multicycle RISC-V core (lw/sw/R/I/beq/jal). |
// | Optional perf counters: define MULTICYCLE_CTRL_PERF_EN.          |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module multicycle_controller
    import riscv_ctrl_pkg::*;
#(
    parameter logic [3:0] RESET_STATE = FETCH,
    parameter int         XLEN        = 32
)(
    input  wire logic                 clk,
    input  wire logic                 reset,
    multicycle_controller_if.master   bus
`ifdef MULTICYCLE_CTRL_PERF_EN
    ,
    output logic [XLEN-1:0]           instret,
    output logic [XLEN-1:0]           stall_cycles
`endif
);
    logic [3:0] r_state;
    logic [3:0] w_next;
    logic       w_pc_update;
    logic       w_branch;
    logic       w_adr_src;
    logic       w_mem_write;
    logic       w_ir_write;
    logic [1:0] w_result_src;
    logic [1:0] w_src_a;
    logic [1:0] w_src_b;
    logic       w_reg_write;
    logic [1:0] w_alu_op;
    logic       w_illegal;
    logic [2:0] w_alu_control;

    always_comb begin
        w_next       = FETCH;
        w_pc_update  = 1'b0;
        w_branch     = 1'b0;
        w_adr_src    = 1'b0;
        w_mem_write  = 1'b0;
        w_ir_write   = 1'b0;
        w_result_src = RES_ALUOUT;
        w_src_a      = SRCA_PC;
        w_src_b      = SRCB_RD2;
        w_reg_write  = 1'b0;
        w_alu_op     = ALUOP_ADD;
        w_illegal    = 1'b0;
        case (r_state)
            FETCH: begin
                w_src_b      = SRCB_FOUR;
                w_result_src = RES_ALURESULT;
                w_ir_write   = bus.MemReady;
                w_pc_update  = bus.MemReady;
                w_next       = bus.MemReady ? DECODE : FETCH;
            end
            DECODE: begin
                // ALU precomputes the branch target OldPC + imm into ALUOut.
                w_src_a = SRCA_OLDPC;
                w_src_b = SRCB_IMM;
                case (bus.op)
                    OP_LW, OP_SW: w_next = MEMADR;
                    OP_R:         w_next = EXECR;
                    OP_I:         w_next = EXECI;
                    OP_BEQ:       w_next = BEQ;
                    OP_JAL:       w_next = JAL;
                    default: begin
                        w_illegal = 1'b1;
                        w_next    = FETCH;
                    end
                endcase
            end
            MEMADR: begin
                w_src_a = SRCA_RD1;
                w_src_b = SRCB_IMM;
                w_next  = bus.op[5] ? MEMWRITE : MEMREAD;
            end
            MEMREAD: begin
                w_adr_src = 1'b1;
                w_next    = bus.MemReady ? MEMWB : MEMREAD;
            end
            MEMWB: begin
                w_result_src = RES_DATA;
                w_reg_write  = 1'b1;
            end
            MEMWRITE: begin
                w_adr_src   = 1'b1;
                w_mem_write = 1'b1;
                w_next      = bus.MemReady ? FETCH : MEMWRITE;
            end
            EXECR: begin
                w_src_a  = SRCA_RD1;
                w_alu_op = ALUOP_FUNCT;
                w_next   = ALUWB;
            end
            EXECI: begin
                w_src_a  = SRCA_RD1;
                w_src_b  = SRCB_IMM;
                w_alu_op = ALUOP_FUNCT;
                w_next   = ALUWB;
            end
            ALUWB: w_reg_write = 1'b1;
            BEQ: begin
                w_src_a  = SRCA_RD1;
                w_alu_op = ALUOP_SUB;
                w_branch = 1'b1;
            end
            JAL: begin
                w_src_a     = SRCA_OLDPC;
                w_src_b     = SRCB_FOUR;
                w_pc_update = 1'b1;
                w_next      = ALUWB;
            end
            default: w_next = FETCH;
        endcase
    end

    alu_decoder u_alu_decoder (
        .alu_op      (w_alu_op),
        .funct3      (bus.funct3),
        .op5         (bus.op[5]),
        .funct7b5    (bus.funct7b5),
        .alu_control (w_alu_control)
    );

    always_ff @(posedge clk) begin
        if (reset) r_state <= RESET_STATE;
        else       r_state <= w_next;
    end

    // Reset masks every output so an aborted instruction cannot write.
    always_comb begin
        bus.PCWrite      = ~reset & (w_pc_update | (w_branch & bus.Zero));
        bus.AdrSrc       = ~reset & w_adr_src;
        bus.MemWrite     = ~reset & w_mem_write;
        bus.IRWrite      = ~reset & w_ir_write;
        bus.ResultSrc    = reset ? 2'b00 : w_result_src;
        bus.ALUSrcA      = reset ? 2'b00 : w_src_a;
        bus.ALUSrcB      = reset ? 2'b00 : w_src_b;
        bus.RegWrite     = ~reset & w_reg_write;
        bus.ImmSrc       = reset ? 2'b00 : imm_src_of(bus.op);
        bus.ALUControl   = reset ? 3'b000 : w_alu_control;
        bus.IllegalInstr = ~reset & w_illegal;
    end

`ifdef MULTICYCLE_CTRL_PERF_EN
    logic w_retire;
    logic w_stall;

    assign w_retire = ((r_state == MEMWB) || (r_state == MEMWRITE) ||
                       (r_state == ALUWB) || (r_state == BEQ)) && (w_next == FETCH);
    assign w_stall  = ((r_state == FETCH) || (r_state == MEMREAD) ||
                       (r_state == MEMWRITE)) && !bus.MemReady;

    always_ff @(posedge clk) begin
        if (reset) begin
            instret      <= '0;
            stall_cycles <= '0;
        end else begin
            if (w_retire) instret      <= instret + {{(XLEN-1){1'b0}}, 1'b1};
            if (w_stall)  stall_cycles <= stall_cycles + {{(XLEN-1){1'b0}}, 1'b1};
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_multicycle_controller.sv
`default_nettype none
// Cycle-by-cycle vector table for the multicycle controller, plus a
// hand-driven reset-abort sequence during a store.
module tb_multicycle_controller;

    typedef struct {
        string       name;
        logic        rst;
        logic [6:0]  op;
        logic [2:0]  f3;
        logic        f7;
        logic        zero;
        logic        mr;
        logic [16:0] exp;
    } vec_t;

    localparam logic [6:0] T_LW  = 7'b0000011;
    localparam logic [6:0] T_SW  = 7'b0100011;
    localparam logic [6:0] T_R   = 7'b0110011;
    localparam logic [6:0] T_I   = 7'b0010011;
    localparam logic [6:0] T_BEQ = 7'b1100011;
    localparam logic [6:0] T_JAL = 7'b1101111;
    localparam logic [6:0] T_BAD = 7'b1110011;

    logic clk;
    logic reset;
    int   checks;
    int   fails;
    vec_t vecs[$];
    logic [16:0] sb_q[$];

    multicycle_controller_if bus();

`ifdef MULTICYCLE_CTRL_PERF_EN
    logic [31:0] instret;
    logic [31:0] stall_cycles;
    multicycle_controller dut (.clk(clk), .reset(reset), .bus(bus.master),
                               .instret(instret), .stall_cycles(stall_cycles));
`else
    multicycle_controller dut (.clk(clk), .reset(reset), .bus(bus.master));
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // {PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
    //  RegWrite, ImmSrc, ALUControl, IllegalInstr}
    function automatic logic [16:0] e(input logic pcw, input logic adr,
                                      input logic mw, input logic irw,
                                      input logic [1:0] rs, input logic [1:0] sa,
                                      input logic [1:0] sbs, input logic rw,
                                      input logic [1:0] imm, input logic [2:0] alu,
                                      input logic ill);
        return {pcw, adr, mw, irw, rs, sa, sbs, rw, imm, alu, ill};
    endfunction

    function automatic logic [16:0] actual();
        return {bus.PCWrite, bus.AdrSrc, bus.MemWrite, bus.IRWrite, bus.ResultSrc,
                bus.ALUSrcA, bus.ALUSrcB, bus.RegWrite, bus.ImmSrc, bus.ALUControl,
                bus.IllegalInstr};
    endfunction

    task automatic add(input string n, input logic rst, input logic [6:0] op,
                       input logic [2:0] f3, input logic f7, input logic zero,
                       input logic mr, input logic [16:0] x);
        vec_t v;
        v.name = n; v.rst = rst; v.op = op; v.f3 = f3; v.f7 = f7;
        v.zero = zero; v.mr = mr; v.exp = x;
        vecs.push_back(v);
    endtask

    // FETCH, DECODE, EXEC, ALUWB for an R- or I-type instruction.
    task automatic add_alu(input string n, input logic [6:0] op, input logic [2:0] f3,
                           input logic f7, input logic [2:0] alu);
        logic [1:0] srcb;
        srcb = (op == T_I) ? 2'b01 : 2'b00;
        add({n, "_fetch"}, 0, op, f3, f7, 0, 1, e(1,0,0,1,2'd2,2'd0,2'd2,0,2'd0,3'd0,0));
        add({n, "_decode"}, 0, op, f3, f7, 0, 1, e(0,0,0,0,2'd0,2'd1,2'd1,0,2'd0,3'd0,0));
        add({n, "_exec"}, 0, op, f3, f7, 0, 1, e(0,0,0,0,2'd0,2'd2,srcb,0,2'd0,alu,0));
        add({n, "_aluwb"}, 0, op, f3, f7, 0, 1, e(0,0,0,0,2'd0,2'd0,2'd0,1,2'd0,3'd0,0));
    endtask

    task automatic check(input string n, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: actual %0h required %0h", n, act, req);
        end
    endtask

    task automatic drive(input logic rst, input logic [6:0] op, input logic [2:0] f3,
                         input logic f7, input logic zero, input logic mr);
        reset = rst; bus.op = op; bus.funct3 = f3; bus.funct7b5 = f7;
        bus.Zero = zero; bus.MemReady = mr;
    endtask

    initial begin
        bit seen;
        logic [16:0] expv;
        checks = 0;
        fails  = 0;
        drive(1, T_R, 3'b000, 0, 0, 1);

        add("reset0", 1, T_R, 3'b000, 0, 0, 1, 17'd0);
        add("reset1", 1, T_R, 3'b000, 0, 0, 1, 17'd0);
        add_alu("r_add",  T_R, 3'b000, 0, 3'b000);
        add_alu("r_sub",  T_R, 3'b000, 1, 3'b001);
        add_alu("r_slt",  T_R, 3'b010, 0, 3'b101);
        add_alu("r_and",  T_R, 3'b111, 0, 3'b010);
        add_alu("i_ori",  T_I, 3'b110, 0, 3'b011);
        add_alu("i_addi", T_I, 3'b000, 1, 3'b000);
        add_alu("i_xori", T_I, 3'b100, 0, 3'b000);
        add("lw_fetch",  0, T_LW, 3'b010, 0, 0, 1, e(1,0,0,1,2'd2,2'd0,2'd2,0,2'd0,3'd0,0));
        add("lw_decode", 0, T_LW, 3'b010, 0, 0, 1, e(0,0,0,0,2'd0,2'd1,2'd1,0,2'd0,3'd0,0));
        add("lw_memadr", 0, T_LW, 3'b010, 0, 0, 1, e(0,0,0,0,2'd0,2'd2,2'd1,0,2'd0,3'd0,0));
        add("lw_rd_st0", 0, T_LW, 3'b010, 0, 0, 0, e(0,1,0,0,2'd0,2'd0,2'd0,0,2'd0,3'd0,0));
        add("lw_rd_st1", 0, T_LW, 3'b010, 0, 0, 0, e(0,1,0,0,2'd0,2'd0,2'd0,0,2'd0,3'd0,0));
        add("lw_rd_ok",  0, T_LW, 3'b010, 0, 0, 1, e(0,1,0,0,2'd0,2'd0,2'd0,0,2'd0,3'd0,0));
        add("lw_memwb",  0, T_LW, 3'b010, 0, 0, 1, e(0,0,0,0,2'd1,2'd0,2'd0,1,2'd0,3'd0,0));
        add("sw_fetch",  0, T_SW, 3'b010, 0, 0, 1, e(1,0,0,1,2'd2,2'd0,2'd2,0,2'd1,3'd0,0));
        add("sw_decode", 0, T_SW, 3'b010, 0, 0, 1, e(0,0,0,0,2'd0,2'd1,2'd1,0,2'd1,3'd0,0));
        add("sw_memadr", 0, T_SW, 3'b010, 0, 0, 1, e(0,0,0,0,2'd0,2'd2,2'd1,0,2'd1,3'd0,0));
        add("sw_wr_st",  0, T_SW, 3'b010, 0, 0, 0, e(0,1,1,0,2'd0,2'd0,2'd0,0,2'd1,3'd0,0));
        add("sw_wr_ok",  0, T_SW, 3'b010, 0, 0, 1, e(0,1,1,0,2'd0,2'd0,2'd0,0,2'd1,3'd0,0));
        add("beqt_fetch",  0, T_BEQ, 3'b000, 0, 1, 1, e(1,0,0,1,2'd2,2'd0,2'd2,0,2'd2,3'd0,0));
        add("beqt_decode", 0, T_BEQ, 3'b000, 0, 1, 1, e(0,0,0,0,2'd0,2'd1,2'd1,0,2'd2,3'd0,0));
        add("beqt_beq",    0, T_BEQ, 3'b000, 0, 1, 1, e(1,0,0,0,2'd0,2'd2,2'd0,0,2'd2,3'd1,0));
        add("beqn_fetch",  0, T_BEQ, 3'b000, 0, 0, 1, e(1,0,0,1,2'd2,2'd0,2'd2,0,2'd2,3'd0,0));
        add("beqn_decode", 0, T_BEQ, 3'b000, 0, 0, 1, e(0,0,0,0,2'd0,2'd1,2'd1,0,2'd2,3'd0,0));
        add("beqn_beq",    0, T_BEQ, 3'b000, 0, 0, 1, e(0,0,0,0,2'd0,2'd2,2'd0,0,2'd2,3'd1,0));
        add("jal_fetch",  0, T_JAL, 3'b000, 0, 0, 1, e(1,0,0,1,2'd2,2'd0,2'd2,0,2'd3,3'd0,0));
        add("jal_decode", 0, T_JAL, 3'b000, 0, 0, 1, e(0,0,0,0,2'd0,2'd1,2'd1,0,2'd3,3'd0,0));
        add("jal_jal",    0, T_JAL, 3'b000, 0, 0, 1, e(1,0,0,0,2'd0,2'd1,2'd2,0,2'd3,3'd0,0));
        add("jal_aluwb",  0, T_JAL, 3'b000, 0, 0, 1, e(0,0,0,0,2'd0,2'd0,2'd0,1,2'd3,3'd0,0));
        add("ill_fetch",  0, T_BAD, 3'b000, 0, 0, 1, e(1,0,0,1,2'd2,2'd0,2'd2,0,2'd0,3'd0,0));
        add("ill_decode", 0, T_BAD, 3'b000, 0, 0, 1, e(0,0,0,0,2'd0,2'd1,2'd1,0,2'd0,3'd0,1));
        add("ill_fetch_st", 0, T_BAD, 3'b000, 0, 0, 0, e(0,0,0,0,2'd2,2'd0,2'd2,0,2'd0,3'd0,0));
        add("ill_fetch_ok", 0, T_BAD, 3'b000, 0, 0, 1, e(1,0,0,1,2'd2,2'd0,2'd2,0,2'd0,3'd0,0));

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].rst, vecs[i].op, vecs[i].f3, vecs[i].f7, vecs[i].zero, vecs[i].mr);
            sb_q.push_back(vecs[i].exp);
            @(negedge clk);
            expv = sb_q.pop_front();
            check(vecs[i].name, {15'd0, actual()}, {15'd0, expv});
            @(posedge clk);
            #1;
        end

        // Reset asserted while a store is stalled in MEMWRITE.
        drive(1, T_SW, 3'b010, 0, 0, 1);
        @(posedge clk); #1;
        reset = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 10 && !seen; c++) begin
            @(negedge clk);
            if (bus.MemWrite === 1'b1) seen = 1'b1;
            else begin
                @(posedge clk); #1;
            end
        end
        check("abort_reach_memwrite", {31'd0, seen}, 32'd1);
        bus.MemReady = 1'b0;
        #1;
        check("abort_still_writing", {31'd0, bus.MemWrite}, 32'd1);
        reset = 1'b1;
        #1;
        check("abort_memwrite_drop", {31'd0, bus.MemWrite}, 32'd0);
        @(posedge clk); #1;
        drive(0, T_SW, 3'b010, 0, 0, 1);
        @(negedge clk);
        check("abort_refetch_irwrite", {31'd0, bus.IRWrite}, 32'd1);
        check("abort_refetch_srcb", {30'd0, bus.ALUSrcB}, 32'd2);
        @(posedge clk); #1;
        @(negedge clk);
        check("abort_decode_srca", {30'd0, bus.ALUSrcA}, 32'd1);
        check("abort_decode_nowrite", {31'd0, bus.MemWrite | bus.RegWrite}, 32'd0);
        check("scoreboard_empty", sb_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Sequencing FSM that converts the single-cycle RISC-V datapath into a multicycle core sharing one ALU and one unified memory port.
- Decodes op/funct fields and drives every datapath select and write enable, one state per cycle.
- Stalls on the memory handshake.
- Covers lw, sw, R-type, I-type ALU, beq and jal.

Parameters:
- RESET_STATE, 4'd0 (FETCH), state entered on reset.
- XLEN, 32, data width (used only by the optional counter).

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high reset
- op  in  7  Instr[6:0] from the instruction register
- funct3  in  3  Instr[14:12]
- funct7b5  in  1  Instr[30]
- Zero  in  1  ALU zero flag
- MemReady  in  1  memory completes the current access this cycle
- PCWrite  out  1  PC register enable
- AdrSrc  out  1  memory address select: 0 = PC, 1 = Result
- MemWrite  out  1  memory write strobe
- IRWrite  out  1  instruction register and OldPC enable
- ResultSrc  out  2  00 = ALUOut, 01 = Data, 10 = ALUResult
- ALUSrcA  out  2  00 = PC, 01 = OldPC, 10 = RD1
- ALUSrcB  out  2  00 = RD2, 01 = ImmExt, 10 = constant 4
- RegWrite  out  1  register file write enable
- ImmSrc  out  2  00 = I, 01 = S, 10 = B, 11 = J
- ALUControl  out  3  000 = add, 001 = sub, 010 = and, 011 = or, 101 = slt
- IllegalInstr  out  1  one-cycle pulse when DECODE sees an unsupported opcode

Behaviour:
- Reset: state <= FETCH at the clock edge where reset = 1.
  - While reset = 1, PCWrite, IRWrite, MemWrite, RegWrite and IllegalInstr are forced to 0.
  - All selects are 0 and ALUControl = 000 during reset.
  - Reset mid-instruction aborts that instruction and causes no write.
- Outputs are combinational from state and the decoded inputs; there is no output register.
- PCWrite = PCUpdate | (Branch & Zero).
- ImmSrc is decoded combinationally from op:
  - lw/I-type = 00, sw = 01, beq = 10, jal = 11, any other op = 00.
- ALUOp rules:
  - ALUOp 00 gives add; ALUOp 01 gives sub.
  - ALUOp 10 decodes funct3:
    - 000 gives sub if op[5] & funct7b5, else add.
    - 010 gives slt; 110 gives or; 111 gives and.
    - Any other funct3 gives add.
- FETCH: AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10.
  - If MemReady: IRWrite=1, PCUpdate=1, next state DECODE.
  - Otherwise hold in FETCH with IRWrite=0 and PCWrite=0.
- DECODE: ALUSrcA=01, ALUSrcB=01, ALUOp=00 (computes the branch target). Next state by op:
  - 0000011 or 0100011: MEMADR
  - 0110011: EXECR
  - 0010011: EXECI
  - 1100011: BEQ
  - 1101111: JAL
  - anything else: IllegalInstr=1, next state FETCH (instruction dropped, PC already advanced)
- MEMADR: ALUSrcA=10, ALUSrcB=01, ALUOp=00. Next state MEMREAD if op[5]=0, MEMWRITE if op[5]=1.
- MEMREAD: ResultSrc=00, AdrSrc=1. Hold until MemReady, then MEMWB.
- MEMWB: ResultSrc=01, RegWrite=1, then FETCH.
- MEMWRITE: ResultSrc=00, AdrSrc=1, MemWrite=1 held for every cycle of the stall. Go to FETCH on MemReady.
- EXECR: ALUSrcA=10, ALUSrcB=00, ALUOp=10, then ALUWB.
- EXECI: ALUSrcA=10, ALUSrcB=01, ALUOp=10, then ALUWB.
- ALUWB: ResultSrc=00, RegWrite=1, then FETCH.
- BEQ: ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00, Branch=1, then FETCH.
- JAL: ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, PCUpdate=1, then ALUWB.
- Latency without stalls:
  - lw 5 cycles, sw 4, R/I 4, beq 3, jal 4.
  - Each MemReady-low cycle adds one cycle.
- Unused state encodings go to FETCH with no writes asserted.

Optional Feature:
- Macro: MULTICYCLE_CTRL_PERF_EN.
- Defined: adds output instret [XLEN-1:0] and output stall_cycles [XLEN-1:0].
  - Both counters clear on reset.
  - instret increments on each transition into FETCH from MEMWB, MEMWRITE, ALUWB or BEQ.
  - stall_cycles increments for each FETCH, MEMREAD or MEMWRITE cycle with MemReady=0.
  - Both wrap modulo 2^XLEN.
- Undefined: neither port nor counter exists; the rest of the behaviour is identical.

Decomposition:
- Package riscv_ctrl_pkg holds:
  - opcode constants: OP_LW, OP_SW, OP_R, OP_I, OP_BEQ, OP_JAL
  - ALUControl codes
  - ALUOp codes
  - ResultSrc, ALUSrcA, ALUSrcB and ImmSrc encodings
  - the 4-bit state encoding (FETCH=0 through JAL=10)
- One sub-module, alu_decoder: combinational map from ALUOp, funct3, op[5] and funct7b5 to ALUControl.

Test Plan:
- Reset held 2 cycles, then released with MemReady=1 → state is FETCH and all enables are 0 during reset; IRWrite=1, PCWrite=1 and ALUSrcB=10 in the first cycle after release.
- R-type add (op=0110011, funct3=000, funct7b5=0) → FETCH, DECODE, EXECR (ALUControl=000), ALUWB (RegWrite=1); with funct7b5=1 → ALUControl=001. 4 cycles total.
- lw with MemReady low for 2 cycles in MEMREAD → AdrSrc=1 held for 3 cycles, then MEMWB with ResultSrc=01 and RegWrite=1. 7 cycles total.
- sw with MemReady=0 for 1 cycle → MemWrite=1 for 2 consecutive cycles and ImmSrc=01; back to FETCH.
- beq with Zero=1 → PCWrite=1 and ALUControl=001 in BEQ; with Zero=0 → PCWrite=0. 3 cycles either way.
- op=1110011 → IllegalInstr pulses for 1 cycle in DECODE, next state FETCH, no RegWrite or MemWrite.
- Assert reset in MEMWRITE → MemWrite drops the same cycle; FETCH on the next cycle.
